div_rate_ctrl: RTL
==================

Name: div_rate_ctrl

Overview:
- Run-time controller for the 1 MHz-derived slow clocks. It generates a programmable 50%-duty clock and a matching single-cycle tick strobe.
- Software or the FSM master changes the rate through a valid/ready config handshake. Rate changes take effect only at period boundaries, so there are no glitches or runt phases.
- Start/stop sequencing always completes the current high phase before halting.
- Sits beside the fixed 10 kHz/100 kHz divider. Downstream logic uses it when the rate must change during operation.

Parameters:
- CNT_W, 16, width of half-period counter and config value.
- RESET_HALF, 4, half-period terminal count loaded at reset (4 gives 100 kHz).

Ports:
- clock1M  input  1  system clock, 1 MHz.
- reset  input  1  asynchronous, active-high.
- enable  input  1  level; 1 = run, 0 = stop after current high phase.
- cfg_valid  input  1  new half-period value offered.
- cfg_half  input  CNT_W  terminal count; half period = cfg_half+1 cycles.
- cfg_ready  output  1  controller can accept a config word.
- clk_out  output  1  generated clock.
- tick  output  1  one-cycle pulse, coincident with clk_out rising.
- running  output  1  FSM in RUN or DRAIN.
- cfg_pending  output  1  accepted config not yet applied.

Behaviour:
- All outputs are registered. Values during and after reset:
  - clk_out=0, tick=0, running=0, cfg_pending=0, cfg_ready=1.
  - Active half register = RESET_HALF, counter = 0, FSM = IDLE.
- The counter counts 0..half_act. The terminal cycle (cnt==half_act) toggles clk_out and clears cnt. The resulting period is 2*(half_act+1) cycles.
- tick is registered high for exactly one cycle, in the same cycle that clk_out becomes 1 (terminal cycle with clk_out==0).
- FSM states:
  - IDLE:
    - Holds clk_out=0 and cnt=0; tick=0.
    - enable=1 moves to RUN next cycle. The first rising edge of clk_out occurs half_act+1 cycles after entering RUN.
  - RUN:
    - Normal counting.
    - If enable=0 at a terminal cycle with clk_out==0, go to IDLE. No rising edge is produced.
    - If enable=0 at any other time, go to DRAIN.
  - DRAIN:
    - Keeps counting.
    - At the terminal cycle where clk_out goes 1→0, go to IDLE with cnt=0.
    - If enable returns to 1 during DRAIN, go back to RUN with no phase disturbance.
- Config handshake:
  - The transfer happens when cfg_valid&&cfg_ready. cfg_half is captured into a shadow register, cfg_pending=1 and cfg_ready=0 the next cycle.
  - cfg_ready = !cfg_pending; it is not combinationally dependent on cfg_valid.
- Config apply:
  - In IDLE, the shadow is applied the cycle after capture.
  - In RUN/DRAIN, it is applied only on the terminal cycle where clk_out goes 1→0. Both halves of any single period therefore use the same value.
  - On apply, half_act=shadow, cfg_pending=0, cfg_ready=1 next cycle.
- Boundary and corner cases:
  - cfg_half=0 is legal: clk_out toggles every cycle (500 kHz), and tick occurs every 2 cycles.
  - cfg_half=2^CNT_W-1 is legal. The counter must never wrap past half_act.
  - Apply and capture in the same cycle cannot happen, because cfg_ready=0 while a config is pending.
  - A stop (IDLE entry) coinciding with an apply: both take effect.
  - Reset mid-operation: immediate return to the reset values above, and any pending config is discarded.

Optional Feature:
- Macro: DIV_RATE_CTRL_TICKCNT_EN.
- Defined: adds output tick_count [15:0].
  - Increments on every tick and wraps 0xFFFF→0.
  - Cleared by reset and on every config apply.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then enable=1 with default RESET_HALF=4 → first clk_out rise 5 cycles after RUN entry, period 10 cycles, tick every 10 cycles and aligned with each rise.
- In RUN at half=4, send cfg_half=49 mid-high-phase → cfg_ready low and cfg_pending high from the next cycle. The current period completes with 5-cycle halves, and the following period is 100 cycles with 50-cycle halves; cfg_ready returns to 1 after the falling edge.
- Drop enable 2 cycles into a high phase at half=4 → clk_out stays high for the full 5 cycles, then falls; running=0 after that edge, with no further tick.
- Drop enable during DRAIN, then re-raise it before the falling edge → clk_out period stays exactly 10 cycles and running stays 1.
- cfg_half=0 while IDLE, then enable → clk_out toggles every cycle and tick pulses every 2 cycles. Pulse reset mid-run → all outputs reach their reset values immediately and cfg_ready=1.
- With DIV_RATE_CTRL_TICKCNT_EN defined: run 3 ticks → tick_count=3; apply a new config → tick_count=0.

Source files
------------

// File: rtl/div_rate_ctrl.sv
// div_rate_ctrl: run-time programmable 50%-duty clock generator with tick strobe.
// A new half-period is offered through a valid/ready handshake. It is held in a
// shadow register and applied only at a period boundary, so the output never
// glitches and never produces a runt phase. When enable drops, the controller
// finishes the current high phase before it halts.
// Optional build macro DIV_RATE_CTRL_TICKCNT_EN adds a 16-bit tick_count output.
// This counter counts ticks and is cleared whenever a new configuration is applied.

module div_rate_ctrl #(
  parameter int CNT_W      = 16,
  parameter int RESET_HALF = 4
) (
  input  logic             clock1M,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic             cfg_pending
`ifdef DIV_RATE_CTRL_TICKCNT_EN
  ,
  output logic [15:0]      tick_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_act_q, half_act_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             running_q, running_d;
  logic             cfg_pending_q, cfg_pending_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             apply;
  logic             capture;
  logic             terminal;
`ifdef DIV_RATE_CTRL_TICKCNT_EN
  logic [15:0]      tick_count_q, tick_count_d;
`endif

  // Next-state logic: phase counting, start/stop sequencing, config capture and apply
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    clk_out_d     = clk_out_q;
    tick_d        = 1'b0;
    half_act_d    = half_act_q;
    shadow_d      = shadow_q;
    cfg_pending_d = cfg_pending_q;
    apply         = 1'b0;
    capture       = cfg_valid && cfg_ready_q;
    terminal      = (cnt_q == half_act_q);

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        apply     = cfg_pending_q;
        if (enable) begin
          state_d = RUN;
        end
      end
      RUN, DRAIN: begin
        if (terminal) begin
          cnt_d = '0;
          if (!clk_out_q) begin
            if (enable) begin
              clk_out_d = 1'b1;
              tick_d    = 1'b1;
              state_d   = RUN;
            end else begin
              state_d = IDLE;
            end
          end else begin
            clk_out_d = 1'b0;
            apply     = cfg_pending_q;
            state_d   = enable ? RUN : IDLE;
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = enable ? RUN : DRAIN;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        clk_out_d = 1'b0;
      end
    endcase

    if (capture) begin
      shadow_d      = cfg_half;
      cfg_pending_d = 1'b1;
    end
    if (apply) begin
      half_act_d    = shadow_q;
      cfg_pending_d = 1'b0;
    end

    cfg_ready_d = !cfg_pending_d;
    running_d   = (state_d != IDLE);
  end

`ifdef DIV_RATE_CTRL_TICKCNT_EN
  // Tick counter update: restart on config apply, otherwise count each tick
  always_comb begin
    tick_count_d = tick_count_q;
    if (apply) begin
      tick_count_d = 16'd0;
    end else if (tick_d) begin
      tick_count_d = tick_count_q + 16'd1;
    end
  end

  // Tick counter register
  always_ff @(posedge clock1M or posedge reset) begin
    if (reset) begin
      tick_count_q <= 16'd0;
    end else begin
      tick_count_q <= tick_count_d;
    end
  end

  assign tick_count = tick_count_q;
`endif

  // State and output registers; reset discards any pending configuration
  always_ff @(posedge clock1M or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      half_act_q    <= CNT_W'(RESET_HALF);
      shadow_q      <= '0;
      clk_out_q     <= 1'b0;
      tick_q        <= 1'b0;
      running_q     <= 1'b0;
      cfg_pending_q <= 1'b0;
      cfg_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      half_act_q    <= half_act_d;
      shadow_q      <= shadow_d;
      clk_out_q     <= clk_out_d;
      tick_q        <= tick_d;
      running_q     <= running_d;
      cfg_pending_q <= cfg_pending_d;
      cfg_ready_q   <= cfg_ready_d;
    end
  end

  assign clk_out     = clk_out_q;
  assign tick        = tick_q;
  assign running     = running_q;
  assign cfg_pending = cfg_pending_q;
  assign cfg_ready   = cfg_ready_q;

endmodule
